filter_envelope_detector: RTL and testbench

Downstream stage of the digital filter. Consumes the 8-bit filtered sample stream and produces a peak-hold/decay envelope, a hysteretic detect flag and a saturating event counter. Sits between the filter output (uo_out path) and the status/readout logic. It turns the impulse response of the filter into a stable "signal present" indication.

---
 rtl/filter_envelope_detector_pkg.sv | 23 ++
 rtl/filter_envelope_detector_if.sv | 36 +++
 rtl/filter_envelope_detector_sat_counter.sv | 28 ++
 rtl/filter_envelope_detector.sv | 127 ++++++++++++
 tb/tb_filter_envelope_detector.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_envelope_detector_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Shared definitions for the filter datapath and its downstream envelope
// detector: sample width, default detect thresholds and the envelope FSM
// state encoding. The filter, the detector and their benches import this.
// -----------------------------------------------------------------------------
package filter_pkg;

  // Default sample / envelope width (unsigned).
  localparam int DEF_DATA_W = 8;

  // Default hysteresis levels for the detect flag. LO must not exceed HI.
  localparam int DEF_THRESH_HI = 'hC0;
  localparam int DEF_THRESH_LO = 'h40;

  // Envelope FSM. The encoding is visible on state_o, so it is fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DECAY = 2'b10
  } env_state_t;

endpackage : filter_pkg

// File: rtl/filter_envelope_detector_if.sv
// -----------------------------------------------------------------------------
// filter_envelope_detector_if
// Sample-in / status-out bundle of the envelope detector.
//   y_i         filtered sample, unsigned
//   valid_i     qualifies y_i; detector state only moves on valid samples
//   clear_i     synchronous clear of the event counter
//   env_o       registered envelope
//   det_o       registered hysteretic detect flag
//   event_cnt_o saturating count of det_o rising edges
//   state_o     envelope FSM state (00 IDLE, 01 HOLD, 10 DECAY)
// master: the sample source / status reader. slave: the detector.
// -----------------------------------------------------------------------------
interface filter_envelope_detector_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) ();

  logic [DATA_W-1:0] y_i;
  logic              valid_i;
  logic              clear_i;
  logic [DATA_W-1:0] env_o;
  logic              det_o;
  logic [CNT_W-1:0]  event_cnt_o;
  logic [1:0]        state_o;

  modport master (
    output y_i, valid_i, clear_i,
    input  env_o, det_o, event_cnt_o, state_o
  );

  modport slave (
    input  y_i, valid_i, clear_i,
    output env_o, det_o, event_cnt_o, state_o
  );

endinterface : filter_envelope_detector_if

// File: rtl/filter_envelope_detector_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk  clock, rising edge
//   rst  synchronous, active-high reset to 0
//   inc  count up by one this cycle
//   clr  synchronous clear to 0, wins over inc
//   cnt  current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/filter_envelope_detector.sv
// -----------------------------------------------------------------------------
// filter_envelope_detector
// Peak-hold / decay envelope follower on the filtered sample stream, with a
// hysteretic "signal present" flag and a saturating count of detect events.
//   clk    clock, rising edge
//   rst_n  synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   bus    filter_envelope_detector_if.slave (samples in, status out)
// A sample above the envelope captures it and (re)starts the hold window;
// after HOLD_CYC further valid samples the envelope decays by
// max(1, env >> DECAY_SHIFT) per valid sample until it reaches zero.
// All outputs are registered and reflect the sample taken on the prior edge.
// -----------------------------------------------------------------------------
module filter_envelope_detector
  import filter_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                HOLD_CYC    = 16,
  parameter int                DECAY_SHIFT = 3,
  parameter logic [DATA_W-1:0] THRESH_HI   = DATA_W'(DEF_THRESH_HI),
  parameter logic [DATA_W-1:0] THRESH_LO   = DATA_W'(DEF_THRESH_LO),
  parameter int                CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  filter_envelope_detector_if.slave     bus
);

  // hold_cnt only ever holds HOLD_CYC-1 down to 0.
  localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

  env_state_t        state_q, state_d;
  logic [DATA_W-1:0] env_q, env_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              det_q, det_d;
  logic [DATA_W-1:0] dec;
  logic              det_rise;

  // Next-state logic for FSM, envelope and detect flag.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would infer a latch.
    state_d = state_q;
    env_d   = env_q;
    hold_d  = hold_q;
    det_d   = det_q;

    // Proportional decay with a floor of 1 so small envelopes still reach 0.
    dec = env_q >> DECAY_SHIFT;
    if (dec == '0) begin
      dec = DATA_W'(1);
    end

    if (bus.valid_i) begin
      if (bus.y_i > env_q) begin
        // New peak from any state: capture and restart the hold window.
        env_d   = bus.y_i;
        hold_d  = HOLD_LOAD;
        state_d = ST_HOLD;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_HOLD: begin
            if (hold_q == '0) begin
              state_d = ST_DECAY;
            end else begin
              hold_d = hold_q - 1'b1;
            end
          end
          ST_DECAY: begin
            // dec <= env_q whenever env_q is non-zero, so this cannot wrap.
            env_d = env_q - dec;
            if (env_d == '0) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      // Hysteresis on the envelope being registered this edge; between the
      // two levels the previous flag is kept.
      if (env_d >= THRESH_HI) begin
        det_d = 1'b1;
      end else if (env_d < THRESH_LO) begin
        det_d = 1'b0;
      end
    end
  end

  // det_d equals det_q when valid_i is low, so no separate gating is needed.
  assign det_rise = det_d & ~det_q;

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here (synchronous) and is
    // active-high, so it appears as an ordinary if-branch, not in the
    // sensitivity list.
    if (rst_n) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      hold_q  <= '0;
      det_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state_q <= state_d;
      env_q   <= env_d;
      hold_q  <= hold_d;
      det_q   <= det_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_event_cnt (
    .clk (clk),
    .rst (rst_n),
    .inc (det_rise),
    .clr (bus.clear_i),
    .cnt (bus.event_cnt_o)
  );

  assign bus.env_o   = env_q;
  assign bus.det_o   = det_q;
  assign bus.state_o = state_q;

endmodule : filter_envelope_detector

// File: tb/tb_filter_envelope_detector.sv
// -----------------------------------------------------------------------------
// tb_filter_envelope_detector
// Directed bench for filter_envelope_detector. Two instances share clock,
// reset and stimulus: u_dut with an 8-bit event counter and u_dut_sat with a
// 2-bit one for the saturation scenario. Expected envelopes are hand-derived
// from the decay rule env - max(1, env >> 3).
// -----------------------------------------------------------------------------
module tb_filter_envelope_detector;

  logic clk = 1'b0;
  logic rst_n;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  filter_envelope_detector_if #(.DATA_W(8), .CNT_W(8)) bus ();
  filter_envelope_detector_if #(.DATA_W(8), .CNT_W(2)) bus_sat ();

  filter_envelope_detector #(.CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  filter_envelope_detector #(.CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_sat)
  );

  // Apply one set of inputs to both instances across one rising edge, then
  // sample 1 ns after the edge.
  task automatic step(input logic [7:0] y, input logic v, input logic c);
    bus.y_i         = y;
    bus.valid_i     = v;
    bus.clear_i     = c;
    bus_sat.y_i     = y;
    bus_sat.valid_i = v;
    bus_sat.clear_i = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
  endtask

  // Feed zero samples until the envelope returns to IDLE, bounded.
  task automatic decay_to_idle(input string tag);
    int n = 0;
    while ((bus.state_o !== 2'b00) && (n < 80)) begin
      step(8'h00, 1'b1, 1'b0);
      n++;
    end
    n_total++;
    if ((bus.state_o !== 2'b00) || (bus.env_o !== 8'h00))
      $display("FAIL %s_idle state=%b env=%h after %0d samples, want state=00 env=00", tag, bus.state_o, bus.env_o, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) step(8'hAA, 1'b1, 1'b0);
    n_total++;
    if (bus.env_o !== 8'h00) $display("FAIL reset_env got=%h want=00", bus.env_o); else n_pass++;
    n_total++;
    if (bus.det_o !== 1'b0) $display("FAIL reset_det got=%b want=0", bus.det_o); else n_pass++;
    n_total++;
    if (bus.event_cnt_o !== 8'h00) $display("FAIL reset_cnt got=%h want=00", bus.event_cnt_o); else n_pass++;
    n_total++;
    if (bus.state_o !== 2'b00) $display("FAIL reset_state got=%b want=00", bus.state_o); else n_pass++;
    rst_n = 1'b0;
    step(8'hAA, 1'b1, 1'b0);
    n_total++;
    if (bus.env_o !== 8'hAA) $display("FAIL release_env got=%h want=AA", bus.env_o); else n_pass++;
    n_total++;
    if (bus.state_o !== 2'b01) $display("FAIL release_state got=%b want=01", bus.state_o); else n_pass++;
    n_total++;
    if (bus.det_o !== 1'b0) $display("FAIL release_det got=%b want=0", bus.det_o); else n_pass++;
  endtask

  task automatic test_impulse();
    logic [7:0] exp_env [11] = '{8'hE0, 8'hC4, 8'hAC, 8'h97, 8'h85, 8'h75,
                                 8'h67, 8'h5B, 8'h50, 8'h46, 8'h3E};
    logic       exp_det [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    do_reset();
    step(8'hFF, 1'b1, 1'b0);
    n_total++;
    if ({bus.env_o, bus.det_o, bus.event_cnt_o, bus.state_o} !== {8'hFF, 1'b1, 8'h01, 2'b01})
      $display("FAIL impulse_capture env=%h det=%b cnt=%h state=%b want FF 1 01 01",
               bus.env_o, bus.det_o, bus.event_cnt_o, bus.state_o);
    else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      step(8'h00, 1'b1, 1'b0);
      n_total++;
      if (bus.env_o !== 8'hFF) $display("FAIL impulse_hold[%0d] env=%h want=FF", i, bus.env_o); else n_pass++;
    end
    n_total++;
    if (bus.state_o !== 2'b10) $display("FAIL impulse_to_decay state=%b want=10", bus.state_o); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      step(8'h00, 1'b1, 1'b0);
      n_total++;
      if ((bus.env_o !== exp_env[i]) || (bus.det_o !== exp_det[i]))
        $display("FAIL impulse_decay[%0d] env=%h det=%b want env=%h det=%b",
                 i, bus.env_o, bus.det_o, exp_env[i], exp_det[i]);
      else n_pass++;
    end
    decay_to_idle("impulse");
    n_total++;
    if ((bus.det_o !== 1'b0) || (bus.event_cnt_o !== 8'h01))
      $display("FAIL impulse_end det=%b cnt=%h want det=0 cnt=01", bus.det_o, bus.event_cnt_o);
    else n_pass++;
  endtask

  task automatic test_hysteresis();
    logic [7:0] exp_env [9] = '{8'hA8, 8'h93, 8'h81, 8'h71, 8'h63, 8'h57, 8'h4D, 8'h44, 8'h3C};
    logic       exp_det [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    do_reset();
    repeat (4) step(8'hB0, 1'b1, 1'b0);
    n_total++;
    if ({bus.env_o, bus.det_o, bus.event_cnt_o} !== {8'hB0, 1'b0, 8'h00})
      $display("FAIL hyst_below env=%h det=%b cnt=%h want B0 0 00", bus.env_o, bus.det_o, bus.event_cnt_o);
    else n_pass++;
    step(8'hC0, 1'b1, 1'b0);
    n_total++;
    if ({bus.env_o, bus.det_o, bus.event_cnt_o} !== {8'hC0, 1'b1, 8'h01})
      $display("FAIL hyst_at_hi env=%h det=%b cnt=%h want C0 1 01", bus.env_o, bus.det_o, bus.event_cnt_o);
    else n_pass++;
    repeat (17) step(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step(8'h00, 1'b1, 1'b0);
      n_total++;
      if ((bus.env_o !== exp_env[i]) || (bus.det_o !== exp_det[i]))
        $display("FAIL hyst_decay[%0d] env=%h det=%b want env=%h det=%b",
                 i, bus.env_o, bus.det_o, exp_env[i], exp_det[i]);
      else n_pass++;
    end
    step(8'hC0, 1'b1, 1'b0);
    n_total++;
    if ({bus.env_o, bus.det_o, bus.event_cnt_o, bus.state_o} !== {8'hC0, 1'b1, 8'h02, 2'b01})
      $display("FAIL hyst_repulse env=%h det=%b cnt=%h state=%b want C0 1 02 01",
               bus.env_o, bus.det_o, bus.event_cnt_o, bus.state_o);
    else n_pass++;
  endtask

  task automatic test_gating();
    do_reset();
    step(8'hFF, 1'b1, 1'b0);
    repeat (3) step(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      // clear_i still acts while samples are gated off.
      step(8'hFF, 1'b0, (i == 4));
      n_total++;
      if ((bus.env_o !== 8'hFF) || (bus.state_o !== 2'b01) || (bus.det_o !== 1'b1))
        $display("FAIL gate_frozen[%0d] env=%h state=%b det=%b want FF 01 1",
                 i, bus.env_o, bus.state_o, bus.det_o);
      else n_pass++;
    end
    n_total++;
    if (bus.event_cnt_o !== 8'h00) $display("FAIL gate_clear cnt=%h want=00", bus.event_cnt_o); else n_pass++;
    repeat (12) step(8'h00, 1'b1, 1'b0);
    n_total++;
    if ((bus.state_o !== 2'b01) || (bus.env_o !== 8'hFF))
      $display("FAIL gate_resume_hold state=%b env=%h want 01 FF", bus.state_o, bus.env_o);
    else n_pass++;
    step(8'h00, 1'b1, 1'b0);
    n_total++;
    if ((bus.state_o !== 2'b10) || (bus.env_o !== 8'hFF))
      $display("FAIL gate_resume_decay state=%b env=%h want 10 FF", bus.state_o, bus.env_o);
    else n_pass++;
    step(8'h00, 1'b1, 1'b0);
    n_total++;
    if (bus.env_o !== 8'hE0) $display("FAIL gate_first_step env=%h want=E0", bus.env_o); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int p = 0; p < 5; p++) begin
      step(8'hFF, 1'b1, 1'b0);
      n_total++;
      if ((bus_sat.event_cnt_o !== exp_sat[p]) || (bus.event_cnt_o !== 8'(p + 1)))
        $display("FAIL sat_pulse[%0d] cnt2=%0d cnt8=%0d want cnt2=%0d cnt8=%0d",
                 p, bus_sat.event_cnt_o, bus.event_cnt_o, exp_sat[p], p + 1);
      else n_pass++;
      decay_to_idle("sat");
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    step(8'hFF, 1'b1, 1'b0);
    decay_to_idle("clr");
    n_total++;
    if (bus.event_cnt_o !== 8'h01) $display("FAIL clr_pre cnt=%h want=01", bus.event_cnt_o); else n_pass++;
    step(8'hFF, 1'b1, 1'b1);
    n_total++;
    if ((bus.event_cnt_o !== 8'h00) || (bus.det_o !== 1'b1) || (bus_sat.event_cnt_o !== 2'd0))
      $display("FAIL clr_vs_rise cnt=%h det=%b cnt2=%0d want cnt=00 det=1 cnt2=0",
               bus.event_cnt_o, bus.det_o, bus_sat.event_cnt_o);
    else n_pass++;
  endtask

  task automatic test_retrigger();
    do_reset();
    step(8'hA4, 1'b1, 1'b0);
    repeat (17) step(8'h00, 1'b1, 1'b0);
    n_total++;
    if ((bus.env_o !== 8'h90) || (bus.state_o !== 2'b10))
      $display("FAIL retrig_setup env=%h state=%b want 90 10", bus.env_o, bus.state_o);
    else n_pass++;
    step(8'h80, 1'b1, 1'b0);
    n_total++;
    if ((bus.env_o !== 8'h7E) || (bus.state_o !== 2'b10))
      $display("FAIL retrig_lower env=%h state=%b want 7E 10", bus.env_o, bus.state_o);
    else n_pass++;
    step(8'hA0, 1'b1, 1'b0);
    n_total++;
    if ((bus.env_o !== 8'hA0) || (bus.state_o !== 2'b01))
      $display("FAIL retrig_higher env=%h state=%b want A0 01", bus.env_o, bus.state_o);
    else n_pass++;
    repeat (16) step(8'h00, 1'b1, 1'b0);
    n_total++;
    if ((bus.env_o !== 8'hA0) || (bus.state_o !== 2'b10))
      $display("FAIL retrig_hold_len env=%h state=%b want A0 10", bus.env_o, bus.state_o);
    else n_pass++;
    step(8'h00, 1'b1, 1'b0);
    n_total++;
    if (bus.env_o !== 8'h8C) $display("FAIL retrig_decay env=%h want=8C", bus.env_o); else n_pass++;
    rst_n = 1'b1;
    step(8'hFF, 1'b1, 1'b0);
    n_total++;
    if ({bus.env_o, bus.det_o, bus.event_cnt_o, bus.state_o} !== {8'h00, 1'b0, 8'h00, 2'b00})
      $display("FAIL reset_mid_decay env=%h det=%b cnt=%h state=%b want all 0",
               bus.env_o, bus.det_o, bus.event_cnt_o, bus.state_o);
    else n_pass++;
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    step(8'h00, 1'b0, 1'b0);
    test_reset();
    test_impulse();
    test_hysteresis();
    test_gating();
    test_saturation();
    test_clear_priority();
    test_retrigger();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule : tb_filter_envelope_detector
